ram_arbiter: RTL and testbench

- Two-port arbiter/sequencer sharing the single RAM wrapper between instruction fetch (I-port, read-only) and data access (D-port, read/write).
- Selects one requester and holds its command stable through the RAM's FREE→ADDR→DATA sequence.
- Captures load data, returns a one-cycle ready/error response, and guarantees one command-free cycle between accesses so the RAM latency counter restarts cleanly.
- Sits between the core's fetch/memory stages and the cpu_ram_if RAM side.

---
 rtl/ram_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one RAM wrapper between the instruction-fetch port
//             (read-only) and the data port (read/write). Holds the winning
//             command stable through FREE->ADDR->DATA, returns a one-cycle
//             rdy/err pulse, and leaves a command-free cycle between accesses.
//  Options  : RAM_ARB_RR_EN - round-robin arbitration under contention;
//             when undefined the data port has fixed priority.
//  ram_state encoding: 0=RAM_FREE 1=RAM_ADDR 2=RAM_DATA 3=RAM_ERROR
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter logic [7:0] TIMEOUT   = 8'd16,
  parameter int         BIT_WIDTH = 32
) (
  input  logic                 ram_clk,
  input  logic                 nrst,
  // instruction-fetch port
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_load,
  output logic                 i_rdy,
  output logic                 i_err,
  // data port
  input  logic                 d_req,
  input  logic                 d_wen,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [1:0]           d_width,
  input  logic [BIT_WIDTH-1:0] d_store,
  output logic [BIT_WIDTH-1:0] d_load,
  output logic                 d_rdy,
  output logic                 d_err,
  // RAM side
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [BIT_WIDTH-1:0] ram_addr,
  output logic [1:0]           ram_width,
  output logic [BIT_WIDTH-1:0] ram_store,
  input  logic [BIT_WIDTH-1:0] ram_load,
  input  logic [1:0]           ram_state
);

  localparam logic [1:0] c_RAM_DATA  = 2'd2;
  localparam logic [1:0] c_RAM_ERROR = 2'd3;
  localparam logic [1:0] c_WIDTH_HALF = 2'b01;
  localparam logic [1:0] c_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // latched command
  logic                 r_grant_d;   // 1 = data port owns the current access
  logic                 r_last_d;    // 1 = data port was served last
  logic [BIT_WIDTH-1:0] r_addr;
  logic [1:0]           r_width;
  logic [BIT_WIDTH-1:0] r_store;
  logic                 r_wen;
  logic                 r_err;
  logic [BIT_WIDTH-1:0] r_load;
  logic [7:0]           r_cnt;

  // values last presented to the RAM, held while no strobe is active
  logic [BIT_WIDTH-1:0] r_out_addr;
  logic [1:0]           r_out_width;
  logic [BIT_WIDTH-1:0] r_out_store;

  logic w_pick_d;
  logic w_misal;
  logic w_ren;
  logic w_wen;
  logic w_data_ok;
  logic w_fail;

`ifdef RAM_ARB_RR_EN
  // under contention the port not served last wins
  assign w_pick_d = d_req & (~i_req | ~r_last_d);
`else
  // data port always wins simultaneous requests
  assign w_pick_d = d_req;
`endif

  // word access needs addr[1:0]=0, half access needs addr[0]=0 (11 acts as word)
  assign w_misal = (r_width[1] & (|r_addr[1:0])) |
                   ((r_width == c_WIDTH_HALF) & r_addr[0]);

  // State register
  always_ff @(posedge ram_clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and RAM strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    w_wen       = 1'b0;
    w_data_ok   = 1'b0;
    w_fail      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req | d_req) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_misal) begin
          // rejected without touching the RAM
          w_fail      = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_ren = ~r_wen;
          w_wen = r_wen;
          if (ram_state == c_RAM_DATA) begin
            w_data_ok   = 1'b1;
            w_state_nxt = ST_RESP;
          end else if (ram_state == c_RAM_ERROR) begin
            w_fail      = 1'b1;
            w_state_nxt = ST_RESP;
          end else if ((TIMEOUT != 8'd0) && (r_cnt == (TIMEOUT - 8'd1))) begin
            w_fail      = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, load capture, error flag and timeout counter
  always_ff @(posedge ram_clk) begin
    if (!nrst) begin
      r_grant_d <= 1'b0;
      r_last_d  <= 1'b1;
      r_addr    <= '0;
      r_width   <= '0;
      r_store   <= '0;
      r_wen     <= 1'b0;
      r_err     <= 1'b0;
      r_load    <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req | d_req) begin
            r_grant_d <= w_pick_d;
            r_err     <= 1'b0;
            r_load    <= '0;
            r_cnt     <= '0;
            if (w_pick_d) begin
              r_addr  <= d_addr;
              r_width <= d_width;
              r_store <= d_store;
              r_wen   <= d_wen;
            end else begin
              r_addr  <= i_addr;
              r_width <= c_WIDTH_WORD;
              r_store <= '0;
              r_wen   <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_fail) begin
            r_err <= 1'b1;
          end
          if (w_data_ok && !r_wen) begin
            r_load <= ram_load;
          end
        end
        ST_RESP: begin
          r_last_d <= r_grant_d;
          r_cnt    <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Remember the last command driven so idle cycles keep the bus steady
  always_ff @(posedge ram_clk) begin
    if (!nrst) begin
      r_out_addr  <= '0;
      r_out_width <= '0;
      r_out_store <= '0;
    end else if (w_ren | w_wen) begin
      r_out_addr  <= r_addr;
      r_out_width <= r_width;
      r_out_store <= r_store;
    end
  end

  assign ram_ren   = w_ren;
  assign ram_wen   = w_wen;
  assign ram_addr  = (w_ren | w_wen) ? r_addr  : r_out_addr;
  assign ram_width = (w_ren | w_wen) ? r_width : r_out_width;
  assign ram_store = (w_ren | w_wen) ? r_store : r_out_store;

  // response pulse goes only to the granted port
  assign i_rdy  = (r_state == ST_RESP) & ~r_grant_d;
  assign d_rdy  = (r_state == ST_RESP) &  r_grant_d;
  assign i_err  = i_rdy & r_err;
  assign d_err  = d_rdy & r_err;
  assign i_load = i_rdy ? r_load : '0;
  assign d_load = d_rdy ? r_load : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM and a
//             transaction-level reference model (grant, latency, result).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int         c_TO   = 16;
  localparam logic [1:0] RS_FREE = 2'd0, RS_ADDR = 2'd1, RS_DATA = 2'd2, RS_ERR = 2'd3;

  logic        ram_clk = 1'b0;
  logic        nrst;
  logic        i_req, d_req, d_wen;
  logic [31:0] i_addr, d_addr, d_store;
  logic [1:0]  d_width;
  logic [31:0] i_load, d_load;
  logic        i_rdy, i_err, d_rdy, d_err;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic [1:0]  ram_width, ram_state;

  ram_arbiter #(.TIMEOUT(8'd16), .BIT_WIDTH(32)) u_dut (
    .ram_clk(ram_clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_load(i_load), .i_rdy(i_rdy), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_width(d_width),
    .d_store(d_store), .d_load(d_load), .d_rdy(d_rdy), .d_err(d_err),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_width(ram_width), .ram_store(ram_store), .ram_load(ram_load),
    .ram_state(ram_state)
  );

  always #5 ram_clk = ~ram_clk;

  // ---------------- behavioural RAM wrapper ----------------
  logic [31:0] mem [16];
  logic [1:0]  rs;
  int          rcnt;
  int          ram_lat;
  bit          ram_errm, ram_stuck;

  assign ram_state = rs;
  assign ram_load  = (rs == RS_DATA) ? mem[ram_addr[5:2]] : 32'hA5A5_5A5A;

  // RAM handshake sequencing: FREE -> (ADDR x lat) -> DATA/ERROR -> FREE
  always @(posedge ram_clk) begin
    if (!nrst) begin
      rs <= RS_FREE;
    end else begin
      case (rs)
        RS_FREE: if (ram_ren || ram_wen) begin
          if (ram_stuck) rs <= RS_ADDR;
          else if (ram_lat == 0) rs <= ram_errm ? RS_ERR : RS_DATA;
          else begin rs <= RS_ADDR; rcnt <= ram_lat; end
        end
        RS_ADDR: begin
          if (!(ram_ren || ram_wen)) rs <= RS_FREE;
          else if (!ram_stuck) begin
            if (rcnt <= 1) rs <= ram_errm ? RS_ERR : RS_DATA;
            else rcnt <= rcnt - 1;
          end
        end
        default: rs <= RS_FREE;
      endcase
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] sh [16];
  bit          m_last_d;
  bit          i_pend, d_pend;
  logic [31:0] ei_addr, ed_addr, ed_store;
  logic [1:0]  ed_width;
  bit          ed_wen;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                        input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (w)
      2'b00:   r[int'(a)*8 +: 8]      = d[7:0];
      2'b01:   r[int'(a[1])*16 +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] w);
    if (w[1]) return (a[1:0] != 2'b00);
    if (w == 2'b01) return a[0];
    return 1'b0;
  endfunction

  function automatic bit pick_d();
    if (d_pend && !i_pend) return 1'b1;
    if (i_pend && !d_pend) return 1'b0;
`ifdef RAM_ARB_RR_EN
    return !m_last_d;
`else
    return 1'b1;
`endif
  endfunction

  task automatic arm_i(input logic [31:0] a);
    i_pend = 1; ei_addr = a; i_req = 1; i_addr = a;
  endtask

  task automatic arm_d(input bit w, input logic [31:0] a, input logic [1:0] wd, input logic [31:0] s);
    d_pend = 1; ed_wen = w; ed_addr = a; ed_width = wd; ed_store = s;
    d_req = 1; d_wen = w; d_addr = a; d_width = wd; d_store = s;
  endtask

  // Called #1 after the edge that starts an IDLE cycle with requests set up.
  task automatic serve();
    bit          wd, e_wen, mis, err, got;
    logic [31:0] e_addr, e_store, e_load;
    logic [1:0]  e_width;
    int          dur, n, strobes, bad;
    wd      = pick_d();
    e_wen   = wd ? ed_wen   : 1'b0;
    e_addr  = wd ? ed_addr  : ei_addr;
    e_width = wd ? ed_width : 2'b10;
    e_store = ed_store;
    mis     = misaligned(e_addr, e_width);
    err     = mis || ram_errm || ram_stuck;
    if (mis) dur = 2;
    else if (ram_stuck) dur = c_TO + 1;
    else dur = 3 + ram_lat;
    e_load  = (err || e_wen) ? 32'h0 : sh[e_addr[5:2]];
    n = 0; strobes = 0; bad = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge ram_clk);
      if (i_rdy || d_rdy) got = 1;
      else begin
        if (ram_ren || ram_wen) begin
          strobes++;
          if (ram_ren !== ~e_wen || ram_wen !== e_wen || ram_addr !== e_addr ||
              ram_width !== e_width || (e_wen && ram_store !== e_store)) bad++;
        end
        if (rs == RS_DATA && ram_wen)
          mem[ram_addr[5:2]] = merge(mem[ram_addr[5:2]], ram_addr[1:0], ram_width, ram_store);
        n++;
      end
    end
    check("rdy_seen", 32'(got), 32'd1);
    check("rdy_port", {30'd0, i_rdy, d_rdy}, wd ? 32'd1 : 32'd2);
    check("latency", n, dur);
    check("err", 32'(wd ? d_err : i_err), 32'(err));
    check("load", wd ? d_load : i_load, e_load);
    check("resp_idle_bus", {30'd0, ram_ren, ram_wen}, 32'd0);
    check("strobe_cycles", strobes, mis ? 0 : dur - 1);
    check("cmd_fields", bad, 0);
    if (wd && e_wen && !err) sh[e_addr[5:2]] = merge(sh[e_addr[5:2]], e_addr[1:0], e_width, e_store);
    m_last_d = wd;
    @(posedge ram_clk); #1;
    if (wd) begin d_pend = 0; d_req = 0; end
    else begin i_pend = 0; i_req = 0; end
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {26'd0, i_rdy, i_err, d_rdy, d_err, ram_ren, ram_wen} |
               i_load | d_load | ram_addr | ram_store | {30'd0, ram_width}, 32'd0);
  endtask

  function automatic logic [31:0] rand_iaddr();
    logic [31:0] a;
    a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    nrst = 0; i_req = 0; d_req = 0; d_wen = 0;
    i_addr = 0; d_addr = 0; d_width = 0; d_store = 0;
    ram_lat = 0; ram_errm = 0; ram_stuck = 0;
    i_pend = 0; d_pend = 0; m_last_d = 1;
    ed_wen = 0; ed_addr = 0; ed_width = 0; ed_store = 0; ei_addr = 0;
    for (int k = 0; k < 16; k++) begin mem[k] = $urandom; sh[k] = mem[k]; end
    mem[4] = 32'hDEAD_BEEF; sh[4] = 32'hDEAD_BEEF;

    repeat (3) @(posedge ram_clk);
    @(negedge ram_clk);
    check_outputs_zero("reset_outputs");
    @(posedge ram_clk); #1 nrst = 1;

    // fetch from a zero-latency RAM
    ram_lat = 0; arm_i(32'h10); serve();
    // half-word store with three extra RAM cycles, then fetch it back
    ram_lat = 3; arm_d(1, 32'h22, 2'b01, 32'h1234); serve();
    ram_lat = 0; arm_i(32'h20); serve();
    check("store_upper_half", {16'd0, sh[8][31:16]}, 32'h1234);
    // misaligned word load never reaches the RAM
    arm_d(0, 32'h3, 2'b10, 32'h0); serve();

    // both ports requesting continuously
    arm_i(32'h4); arm_d(0, 32'h8, 2'b10, 32'h0);
    for (int k = 0; k < 6; k++) begin
      bit was_d;
      was_d = pick_d();
      serve();
      if (was_d) arm_d(0, {26'd0, 4'(k), 2'b00}, 2'b10, 32'h0);
      else arm_i({26'd0, 4'(k + 3), 2'b00});
    end
    d_req = 0; d_pend = 0;
    while (i_pend || d_pend) serve();

    // RAM never answers: timeout abort
    ram_stuck = 1; arm_d(0, 32'h14, 2'b10, 32'h0); serve(); ram_stuck = 0;

    // reset in the middle of a busy access
    ram_lat = 3; arm_i(32'h8);
    @(posedge ram_clk); #1;
    @(posedge ram_clk); #1;
    nrst = 0; i_req = 0; i_pend = 0;
    @(posedge ram_clk);
    @(negedge ram_clk);
    check_outputs_zero("midbusy_reset_outputs");
    m_last_d = 1;
    @(posedge ram_clk); #1 nrst = 1;
    begin
      int rdys;
      rdys = 0;
      repeat (20) begin @(negedge ram_clk); if (i_rdy || d_rdy) rdys++; end
      check("dropped_access_no_rdy", rdys, 0);
    end
    @(posedge ram_clk); #1;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      ram_lat  = $urandom_range(0, 3);
      ram_errm = ($urandom_range(0, 7) == 0);
      if (!i_pend && $urandom_range(0, 1) == 1) arm_i(rand_iaddr());
      if (!d_pend && $urandom_range(0, 1) == 1)
        arm_d(1'($urandom), {26'd0, 6'($urandom_range(0, 63))}, 2'($urandom), $urandom);
      if (!i_pend && !d_pend)
        arm_d(1'($urandom), {26'd0, 6'($urandom_range(0, 63))}, 2'($urandom), $urandom);
      serve();
    end
    ram_errm = 0;
    while (i_pend || d_pend) serve();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
